isp_frame_gate: RTL and testbench

Frame-integrity gate between the ISP output (`isp_top`) and the DDR3 write port (`ddr3_ctrl_2port`). It forwards packed 32-bit pixels only while the incoming frame geometry matches `source_h` x `source_v`. It suppresses the remainder of any malformed frame, and any frame interrupted by an ISP display-mode change, so the DDR write address never drifts out of alignment. It also passes the vsync through as the DDR `wr_load` and reports per-frame good/bad status.

---
 rtl/isp_frame_gate.sv | 166 ++++++++++++++++
 tb/tb_isp_frame_gate.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/isp_frame_gate.sv
// Frame-integrity gate between the ISP pixel stream and the DDR3 write port.
// Forwards pixels only while the frame geometry matches source_h x source_v.
module isp_frame_gate #(
  parameter int unsigned source_h = 1920,
  parameter int unsigned source_v = 1080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_den,
  input  logic [31:0] in_data,
  input  logic [3:0]  mode_sel,
  output logic        out_load,
  output logic        out_wren,
  output logic [31:0] out_data,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [1:0]  err_code,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [11:0] h_max = 12'(source_h);
  localparam logic [11:0] v_max = 12'(source_v);

  localparam logic [1:0] e_none  = 2'b00;
  localparam logic [1:0] e_short = 2'b01;
  localparam logic [1:0] e_long  = 2'b10;
  localparam logic [1:0] e_rows  = 2'b11;

  typedef enum logic [1:0] {
    SYNC,
    ACTIVE,
    DROP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [11:0] col_cnt;
  logic [11:0] col_n;
  logic [11:0] row_cnt;
  logic [11:0] row_n;
  logic        frame_err;
  logic        ferr_n;
  logic [1:0]  err_code_next;
  logic [1:0]  ecn_n;
  logic        vs_q;
  logic        den_q;
  logic [3:0]  mode_q;

  logic        wren_n;
  logic        good_n;
  logic        bad_n;
  logic [1:0]  code_n;
  logic [15:0] gcnt_n;
  logic [15:0] bcnt_n;

  logic        vs_rise;
  logic        mode_chg;
  logic        pix;
  logic        line_end;

  // Pixels that arrive while vsync is high are not pixels at all.
  assign pix      = in_den & ~in_vsync;
  assign line_end = den_q & ~pix;
  assign vs_rise  = in_vsync & ~vs_q;
  assign mode_chg = (mode_sel != mode_q);

  always_comb begin
    state_n = state;
    col_n   = col_cnt;
    row_n   = row_cnt;
    ferr_n  = frame_err;
    ecn_n   = err_code_next;
    wren_n  = 1'b0;
    good_n  = 1'b0;
    bad_n   = 1'b0;
    code_n  = err_code;
    gcnt_n  = good_cnt;
    bcnt_n  = bad_cnt;

    if (mode_chg) begin
      // Abort silently; counters and status stay as they are.
      state_n = SYNC;
    end else if (vs_rise) begin
      if (state != SYNC) begin
        if (!frame_err && row_cnt == v_max) begin
          good_n = 1'b1;
          gcnt_n = good_cnt + 16'd1;
        end else begin
          bad_n  = 1'b1;
          bcnt_n = bad_cnt + 16'd1;
          code_n = frame_err ? err_code_next : e_rows;
        end
      end
      state_n = ACTIVE;
      col_n   = '0;
      row_n   = '0;
      ferr_n  = 1'b0;
      ecn_n   = e_none;
    end else if (state == ACTIVE) begin
      if (pix) begin
        if (row_cnt == v_max) begin
          ferr_n  = 1'b1;
          ecn_n   = e_rows;
          state_n = DROP;
        end else if (col_cnt == h_max) begin
          ferr_n  = 1'b1;
          ecn_n   = e_long;
          state_n = DROP;
        end else begin
          wren_n = 1'b1;
          col_n  = col_cnt + 12'd1;
        end
      end else if (line_end) begin
        if (col_cnt != h_max) begin
          ferr_n  = 1'b1;
          ecn_n   = e_short;
          state_n = DROP;
        end else begin
          row_n = row_cnt + 12'd1;
          col_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SYNC;
      col_cnt       <= '0;
      row_cnt       <= '0;
      frame_err     <= 1'b0;
      err_code_next <= e_none;
      vs_q          <= 1'b0;
      den_q         <= 1'b0;
      mode_q        <= mode_sel;
      out_load      <= 1'b0;
      out_wren      <= 1'b0;
      out_data      <= '0;
      frame_good    <= 1'b0;
      frame_bad     <= 1'b0;
      err_code      <= e_none;
      good_cnt      <= '0;
      bad_cnt       <= '0;
    end else begin
      state         <= state_n;
      col_cnt       <= col_n;
      row_cnt       <= row_n;
      frame_err     <= ferr_n;
      err_code_next <= ecn_n;
      vs_q          <= in_vsync;
      den_q         <= pix;
      mode_q        <= mode_sel;
      out_load      <= in_vsync;
      out_wren      <= wren_n;
      out_data      <= in_data;
      frame_good    <= good_n;
      frame_bad     <= bad_n;
      err_code      <= code_n;
      good_cnt      <= gcnt_n;
      bad_cnt       <= bcnt_n;
    end
  end

endmodule

// File: tb/tb_isp_frame_gate.sv
// Directed bench for isp_frame_gate with an 8x4 frame geometry.
// Frame table plus hand-built mode-change and reset sequences.
module tb_isp_frame_gate;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vsync;
  logic        in_den;
  logic [31:0] in_data;
  logic [3:0]  mode_sel;
  logic        out_load;
  logic        out_wren;
  logic [31:0] out_data;
  logic        frame_good;
  logic        frame_bad;
  logic [1:0]  err_code;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  isp_frame_gate #(.source_h(8), .source_v(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_vsync   (in_vsync),
    .in_den     (in_den),
    .in_data    (in_data),
    .mode_sel   (mode_sel),
    .out_load   (out_load),
    .out_wren   (out_wren),
    .out_data   (out_data),
    .frame_good (frame_good),
    .frame_bad  (frame_bad),
    .err_code   (err_code),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              vs;
    int              nl;
    bit [4:0][3:0]   ln;
    int              wren;
    int              good;
    int              bad;
    logic [1:0]      code;
    int              gc;
    int              bc;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   wren_seen = 0;
  int   good_seen = 0;
  int   bad_seen = 0;
  int   w0, g0, b0;
  int   fnum = 0;
  logic prev_load = 1'b0;

  vec_t tbl [10];

  function automatic vec_t mk(bit vs, int nl, bit [4:0][3:0] ln,
                              int w, int g, int b, logic [1:0] c,
                              int gc, int bc);
    vec_t v;
    v.vs = vs; v.nl = nl; v.ln = ln;
    v.wren = w; v.good = g; v.bad = b;
    v.code = c; v.gc = gc; v.bc = bc;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick(input logic vs, input logic den,
                      input logic [31:0] d, input logic rst);
    in_vsync = vs;
    in_den   = den;
    in_data  = d;
    reset    = rst;
    @(posedge clk);
    #1;
    if (out_wren) wren_seen++;
    if (frame_good) good_seen++;
    if (frame_bad) bad_seen++;
    chk("load", {31'd0, out_load}, {31'd0, vs & ~rst});
    if (out_wren) chk("data", out_data, d);
    if (frame_good | frame_bad)
      chk("pulse_align", {30'd0, out_load, prev_load}, 32'd2);
    prev_load = out_load;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_flags"},
        {26'd0, out_load, out_wren, frame_good, frame_bad, err_code},
        32'd0);
    chk({n, "_cnts"}, {good_cnt, bad_cnt}, 32'd0);
    chk({n, "_data"}, out_data, 32'd0);
  endtask

  // chg_l = -1 changes mode with the vsync; -2 means no event.
  task automatic frame(input bit vs, input int nl, input bit [4:0][3:0] ln,
                       input int chg_l, input int chg_p,
                       input int rst_l, input int rst_p);
    logic rst;
    w0 = wren_seen; g0 = good_seen; b0 = bad_seen;
    fnum++;
    if (vs) begin
      if (chg_l == -1) mode_sel = mode_sel + 4'd1;
      tick(1'b1, 1'b0, 32'd0, 1'b0);
      tick(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    end
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < int'(ln[l]); p++) begin
        rst = (l == rst_l && p == rst_p);
        if (l == chg_l && p == chg_p) mode_sel = mode_sel + 4'd1;
        tick(1'b0, 1'b1, {8'(fnum), 8'(l), 8'(p), 8'hFF}, rst);
        if (rst) chk_zero("mid_reset");
      end
      tick(1'b0, 1'b0, 32'd0, 1'b0);
      tick(1'b0, 1'b0, 32'd0, 1'b0);
    end
  endtask

  task automatic expect_frame(input string n, input int w, input int g,
                              input int b, input logic [1:0] c,
                              input int gc, input int bc);
    chk({n, "_wren"}, wren_seen - w0, w);
    chk({n, "_good"}, good_seen - g0, g);
    chk({n, "_bad"}, bad_seen - b0, b);
    chk({n, "_code"}, {30'd0, err_code}, {30'd0, c});
    chk({n, "_gcnt"}, {16'd0, good_cnt}, gc);
    chk({n, "_bcnt"}, {16'd0, bad_cnt}, bc);
  endtask

  localparam bit [4:0][3:0] full = {4'd0, 4'd8, 4'd8, 4'd8, 4'd8};
  localparam bit [4:0][3:0] none = '0;

  initial begin
    reset = 1'b1; in_vsync = 1'b0; in_den = 1'b0;
    in_data = '0; mode_sel = 4'd0;

    tbl[0] = mk(0, 4, full, 0, 0, 0, 2'b00, 0, 0);
    tbl[1] = mk(1, 4, full, 32, 0, 0, 2'b00, 0, 0);
    tbl[2] = mk(1, 4, full, 32, 1, 0, 2'b00, 1, 0);
    tbl[3] = mk(1, 4, {4'd0, 4'd8, 4'd7, 4'd8, 4'd8},
                23, 1, 0, 2'b00, 2, 0);
    tbl[4] = mk(1, 4, {4'd0, 4'd8, 4'd8, 4'd8, 4'd9},
                8, 0, 1, 2'b01, 2, 1);
    tbl[5] = mk(1, 5, {4'd8, 4'd8, 4'd8, 4'd8, 4'd8},
                32, 0, 1, 2'b10, 2, 2);
    tbl[6] = mk(1, 4, full, 32, 0, 1, 2'b11, 2, 3);
    tbl[7] = mk(1, 4, full, 32, 1, 0, 2'b11, 3, 3);
    tbl[8] = mk(1, 3, full, 24, 1, 0, 2'b11, 4, 3);
    tbl[9] = mk(1, 4, full, 32, 0, 1, 2'b11, 4, 4);

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0, 1'b1);
    chk_zero("reset_state");

    for (int i = 0; i < 10; i++) begin
      frame(tbl[i].vs, tbl[i].nl, tbl[i].ln, -2, -2, -2, -2);
      expect_frame($sformatf("v%0d", i), tbl[i].wren, tbl[i].good,
                   tbl[i].bad, tbl[i].code, tbl[i].gc, tbl[i].bc);
    end

    // Mode change on the 4th pixel of row 1.
    frame(1, 4, full, 1, 3, -2, -2);
    expect_frame("mode_abort", 11, 1, 0, 2'b11, 5, 4);
    frame(1, 4, full, -2, -2, -2, -2);
    expect_frame("mode_resync", 32, 0, 0, 2'b11, 5, 4);

    // Reset on the 5th pixel of row 2.
    frame(1, 4, full, -2, -2, 2, 4);
    expect_frame("mid_reset", 20, 1, 0, 2'b00, 0, 0);
    frame(1, 4, full, -2, -2, -2, -2);
    expect_frame("post_reset", 32, 0, 0, 2'b00, 0, 0);
    frame(1, 0, none, -2, -2, -2, -2);
    expect_frame("post_reset_close", 0, 1, 0, 2'b00, 1, 0);

    // Mode change coincident with the vsync edge wins.
    frame(1, 4, full, -1, -2, -2, -2);
    expect_frame("mode_at_vsync", 0, 0, 0, 2'b00, 1, 0);
    frame(1, 4, full, -2, -2, -2, -2);
    expect_frame("vsync_resync", 32, 0, 0, 2'b00, 1, 0);
    frame(1, 0, none, -2, -2, -2, -2);
    expect_frame("final_close", 0, 1, 0, 2'b00, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
